// File: rtl/bram_s2p_tester_if.sv
// Port bundle between bram_s2p_tester (master) and the bram_s2p wrapper (slave):
// write data/address/enable out, read address out, read data back.
interface bram_s2p_tester_if #(
    parameter int DATA_W = 40,
    parameter int ADDR_W = 9
);
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] waddr;
    logic              wen;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] dout;

    modport master (output din, waddr, wen, raddr, input dout);
    modport slave  (input din, waddr, wen, raddr, output dout);
endinterface

// File: rtl/bram_s2p_tester.sv
// Write/read-back pattern tester for bram_s2p. Optional inverted second pass
// is enabled by defining BRAM_TEST_INV_PASS_EN.
module bram_s2p_tester #(
    parameter int DATA_W   = 40,
    parameter int ADDR_W   = 9,
    parameter int DEPTH    = 512,
    parameter int READ_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [DATA_W-1:0]     seed_i,
    bram_s2p_tester_if.master     bram,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [9:0]            err_count_o,
    output logic [ADDR_W-1:0]     first_err_addr_o
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t                         state_q, state_d;
    logic [ADDR_W-1:0]              wa_q, wa_d;
    logic [ADDR_W-1:0]              ra_q, ra_d;
    logic                           ph_q, ph_d;
    logic [DATA_W-1:0]              seed_q, seed_d;
    logic [9:0]                     err_q, err_d;
    logic [ADDR_W-1:0]              ferr_q, ferr_d;
    logic [READ_LAT:1]              vld_pipe_q, vld_pipe_d;
    logic [READ_LAT:1][ADDR_W-1:0]  pa_q, pa_d;
    logic                           pending;
`ifdef BRAM_TEST_INV_PASS_EN
    logic                           inv_q, inv_d;
`else
    localparam logic                inv_q = 1'b0;
`endif

    // Address replicated across the word from the LSB up, top bits get a[3:0].
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] s,
                                                  input logic              inv);
        logic [DATA_W-1:0] p;
        for (int i = 0; i < DATA_W; i++) p[i] = a[i % ADDR_W];
        p = s ^ p;
        return inv ? ~p : p;
    endfunction

    always_comb begin
        pending = 1'b0;
        for (int k = 1; k < READ_LAT; k++) pending = pending | vld_pipe_q[k];
    end

    always_comb begin
        state_d = state_q;
        wa_d    = wa_q;
        ra_d    = ra_q;
        ph_d    = ph_q;
        seed_d  = seed_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
`ifdef BRAM_TEST_INV_PASS_EN
        inv_d   = inv_q;
`endif
        bram.wen = 1'b0;

        vld_pipe_d[1] = (state_q == READ);
        pa_d[1]       = ra_q;
        for (int k = 2; k <= READ_LAT; k++) begin
            vld_pipe_d[k] = vld_pipe_q[k-1];
            pa_d[k]       = pa_q[k-1];
        end

        if (vld_pipe_q[READ_LAT] &&
            bram.dout != pattern(pa_q[READ_LAT], seed_q, inv_q)) begin
            if (err_q != 10'd1023) err_d = err_q + 10'd1;
            if (err_q == 10'd0)    ferr_d = pa_q[READ_LAT];
        end

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    seed_d  = seed_i;
                    err_d   = '0;
                    ferr_d  = '0;
                    wa_d    = '0;
                    ph_d    = 1'b0;
`ifdef BRAM_TEST_INV_PASS_EN
                    inv_d   = 1'b0;
`endif
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // The wrapper registers wen, so each word gets a second, idle cycle.
                bram.wen = ~ph_q;
                ph_d     = ~ph_q;
                if (ph_q) begin
                    if (wa_q == LAST) begin
                        ra_d    = '0;
                        state_d = READ;
                    end else begin
                        wa_d = wa_q + 1'b1;
                    end
                end
            end
            READ: begin
                if (ra_q == LAST) state_d = DRAIN;
                else              ra_d = ra_q + 1'b1;
            end
            DRAIN: begin
                if (!pending) begin
`ifdef BRAM_TEST_INV_PASS_EN
                    if (!inv_q) begin
                        inv_d   = 1'b1;
                        wa_d    = '0;
                        ph_d    = 1'b0;
                        state_d = WRITE;
                    end else begin
                        state_d = DONE;
                    end
`else
                    state_d = DONE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            wa_q       <= '0;
            ra_q       <= '0;
            ph_q       <= 1'b0;
            seed_q     <= '0;
            err_q      <= '0;
            ferr_q     <= '0;
            vld_pipe_q <= '0;
            pa_q       <= '0;
`ifdef BRAM_TEST_INV_PASS_EN
            inv_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wa_q       <= wa_d;
            ra_q       <= ra_d;
            ph_q       <= ph_d;
            seed_q     <= seed_d;
            err_q      <= err_d;
            ferr_q     <= ferr_d;
            vld_pipe_q <= vld_pipe_d;
            pa_q       <= pa_d;
`ifdef BRAM_TEST_INV_PASS_EN
            inv_q      <= inv_d;
`endif
        end
    end

    // din/waddr follow the write counter, which freezes outside WRITE.
    assign bram.din         = pattern(wa_q, seed_q, inv_q);
    assign bram.waddr       = wa_q;
    assign bram.raddr       = (state_q == READ) ? ra_q : '0;
    assign busy_o           = (state_q == WRITE) || (state_q == READ) || (state_q == DRAIN);
    assign done_o           = (state_q == DONE);
    assign pass_o           = (state_q == DONE) && (err_q == 10'd0);
    assign err_count_o      = err_q;
    assign first_err_addr_o = ferr_q;
endmodule
